// File: rtl/trsq8_pkg.sv
// Shared TRSQ8 core definitions: datapath widths, the NOP encoding and the
// fetch-stage state type.
package trsq8_pkg;

   localparam int unsigned TRSQ8_ADDR_W  = 13;
   localparam int unsigned TRSQ8_INSTR_W = 15;
   localparam logic [TRSQ8_INSTR_W-1:0] TRSQ8_NOP = '0;

   typedef enum logic [1:0] {
      FETCH_BOOT = 2'd0,
      FETCH_RUN  = 2'd1,
      FETCH_HALT = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/trsq8_fetch.sv
// TRSQ8 instruction-fetch stage: owns the PC, addresses the program ROM,
// captures the ROM word into the IR and offers it to decode with valid/ready.
// Execute can redirect the PC (flushing the IR) or request a halt, during
// which the IR drains and the PC is frozen.
module trsq8_fetch
   import trsq8_pkg::*;
#(
   parameter int unsigned         ADDR_W    = TRSQ8_ADDR_W,
   parameter int unsigned         INSTR_W   = TRSQ8_INSTR_W,
   parameter logic [ADDR_W-1:0]   RESET_VEC = '0
) (
   input  logic               CLK_ip,
   input  logic               RST_N_ip,
   output logic [ADDR_W-1:0]  ROM_ADDR_op,
   input  logic [INSTR_W-1:0] ROM_DATA_ip,
   output logic [INSTR_W-1:0] IR_op,
   output logic [ADDR_W-1:0]  IR_PC_op,
   output logic               IR_VALID_op,
   input  logic               IR_READY_ip,
   input  logic               BR_TAKEN_ip,
   input  logic [ADDR_W-1:0]  BR_ADDR_ip,
   input  logic               HALT_ip,
   output logic               HALTED_op
);

   fetch_state_e       r_state;
   logic [ADDR_W-1:0]  r_pc;
   logic [INSTR_W-1:0] r_ir;
   logic [ADDR_W-1:0]  r_ir_pc;
   logic               r_ir_valid;
   logic               w_load;

   // IR slot is free or being consumed this cycle
   assign w_load = !r_ir_valid || IR_READY_ip;

   // PC, IR and fetch FSM; redirect outranks halt, halt outranks capture
   always_ff @(posedge CLK_ip or negedge RST_N_ip) begin
      if (!RST_N_ip) begin
         r_state    <= FETCH_BOOT;
         r_pc       <= RESET_VEC;
         r_ir       <= INSTR_W'(TRSQ8_NOP);
         r_ir_pc    <= '0;
         r_ir_valid <= 1'b0;
      end else begin
         case (r_state)
            FETCH_BOOT: begin
               r_state <= HALT_ip ? FETCH_HALT : FETCH_RUN;
            end
            FETCH_RUN: begin
               if (BR_TAKEN_ip) begin
                  r_pc       <= BR_ADDR_ip;
                  r_ir_valid <= 1'b0;
                  if (HALT_ip) r_state <= FETCH_HALT;
               end else if (HALT_ip) begin
                  // stop capturing; let decode drain whatever the IR holds
                  if (IR_READY_ip) r_ir_valid <= 1'b0;
                  r_state <= FETCH_HALT;
               end else if (w_load) begin
                  r_ir       <= ROM_DATA_ip;
                  r_ir_pc    <= r_pc;
                  r_ir_valid <= 1'b1;
                  r_pc       <= r_pc + ADDR_W'(1);
               end
            end
            FETCH_HALT: begin
               if (BR_TAKEN_ip) begin
                  r_pc       <= BR_ADDR_ip;
                  r_ir_valid <= 1'b0;
               end else if (IR_READY_ip) begin
                  r_ir_valid <= 1'b0;
               end
               if (!HALT_ip) r_state <= FETCH_RUN;
            end
            default: r_state <= FETCH_BOOT;
         endcase
      end
   end

   assign ROM_ADDR_op = r_pc;
   assign IR_op       = r_ir;
   assign IR_PC_op    = r_ir_pc;
   assign IR_VALID_op = r_ir_valid;
   assign HALTED_op   = (r_state == FETCH_HALT) && !r_ir_valid;

endmodule

// File: tb/tb_trsq8_fetch.sv
// Directed bench for trsq8_fetch against a behavioural ROM.
module tb_trsq8_fetch;

   logic        clk;
   logic        rst_n;
   logic [12:0] rom_addr;
   logic [14:0] rom_data;
   logic [14:0] ir;
   logic [12:0] ir_pc;
   logic        valid;
   logic        ready;
   logic        br;
   logic [12:0] br_addr;
   logic        halt;
   logic        halted;

   int total = 0;
   int bad   = 0;

   function automatic logic [14:0] rom_fn(input logic [12:0] a);
      return {a[6:0], a[12:5]} ^ 15'h2A5B;
   endfunction

   assign rom_data = rom_fn(rom_addr);

   trsq8_fetch #(.ADDR_W(13), .INSTR_W(15), .RESET_VEC(13'd0)) dut (
      .CLK_ip      (clk),
      .RST_N_ip    (rst_n),
      .ROM_ADDR_op (rom_addr),
      .ROM_DATA_ip (rom_data),
      .IR_op       (ir),
      .IR_PC_op    (ir_pc),
      .IR_VALID_op (valid),
      .IR_READY_ip (ready),
      .BR_TAKEN_ip (br),
      .BR_ADDR_ip  (br_addr),
      .HALT_ip     (halt),
      .HALTED_op   (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic goto(input logic [12:0] a);
      br = 1'b1; br_addr = a; ready = 1'b1;
      step();
      br = 1'b0;
      step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; ready = 1'b0; br = 1'b0; br_addr = '0; halt = 1'b0;
      #12;
      total++; if (rom_addr !== 13'd0) begin bad++; $display("FAIL rst_addr got=%h want=%h", rom_addr, 13'd0); end
      total++; if (ir !== 15'd0) begin bad++; $display("FAIL rst_ir got=%h want=%h", ir, 15'd0); end
      total++; if (ir_pc !== 13'd0) begin bad++; $display("FAIL rst_irpc got=%h want=%h", ir_pc, 13'd0); end
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", valid); end
      total++; if (halted !== 1'b0) begin bad++; $display("FAIL rst_halted got=%b want=0", halted); end
   endtask

   task automatic test_sequential();
      @(negedge clk);
      rst_n = 1'b1; ready = 1'b1;
      step();  // BOOT cycle: nothing captured
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL boot_valid got=%b want=0", valid); end
      total++; if (rom_addr !== 13'd0) begin bad++; $display("FAIL boot_addr got=%h want=%h", rom_addr, 13'd0); end
      for (int i = 0; i <= 8; i++) begin
         step();
         total++; if (ir_pc !== 13'(i)) begin bad++; $display("FAIL seq_pc[%0d] got=%h want=%h", i, ir_pc, 13'(i)); end
         total++; if (ir !== rom_fn(13'(i))) begin bad++; $display("FAIL seq_ir[%0d] got=%h want=%h", i, ir, rom_fn(13'(i))); end
         total++; if (valid !== 1'b1) begin bad++; $display("FAIL seq_valid[%0d] got=%b want=1", i, valid); end
      end
   endtask

   task automatic test_branch();
      goto(13'd3);
      total++; if (ir_pc !== 13'd3) begin bad++; $display("FAIL br_pre got=%h want=%h", ir_pc, 13'd3); end
      br = 1'b1; br_addr = 13'd7;
      step();
      br = 1'b0;
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL br_flush got=%b want=0", valid); end
      total++; if (rom_addr !== 13'd7) begin bad++; $display("FAIL br_addr got=%h want=%h", rom_addr, 13'd7); end
      step();
      total++; if (ir_pc !== 13'd7) begin bad++; $display("FAIL br_pc got=%h want=%h", ir_pc, 13'd7); end
      total++; if (ir !== rom_fn(13'd7)) begin bad++; $display("FAIL br_ir got=%h want=%h", ir, rom_fn(13'd7)); end
      total++; if (valid !== 1'b1) begin bad++; $display("FAIL br_valid got=%b want=1", valid); end
   endtask

   task automatic test_stall();
      goto(13'd4);
      ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         total++; if (ir_pc !== 13'd4) begin bad++; $display("FAIL stall_pc[%0d] got=%h want=%h", i, ir_pc, 13'd4); end
         total++; if (ir !== rom_fn(13'd4)) begin bad++; $display("FAIL stall_ir[%0d] got=%h want=%h", i, ir, rom_fn(13'd4)); end
         total++; if (rom_addr !== 13'd5) begin bad++; $display("FAIL stall_addr[%0d] got=%h want=%h", i, rom_addr, 13'd5); end
         total++; if (valid !== 1'b1) begin bad++; $display("FAIL stall_valid[%0d] got=%b want=1", i, valid); end
      end
      ready = 1'b1;
      step();
      total++; if (ir_pc !== 13'd5) begin bad++; $display("FAIL stall_res5 got=%h want=%h", ir_pc, 13'd5); end
      total++; if (ir !== rom_fn(13'd5)) begin bad++; $display("FAIL stall_ir5 got=%h want=%h", ir, rom_fn(13'd5)); end
      step();
      total++; if (ir_pc !== 13'd6) begin bad++; $display("FAIL stall_res6 got=%h want=%h", ir_pc, 13'd6); end
   endtask

   task automatic test_wrap();
      goto(13'h1FFF);
      total++; if (ir_pc !== 13'h1FFF) begin bad++; $display("FAIL wrap_top got=%h want=%h", ir_pc, 13'h1FFF); end
      total++; if (rom_addr !== 13'h0000) begin bad++; $display("FAIL wrap_addr got=%h want=%h", rom_addr, 13'h0000); end
      step();
      total++; if (ir_pc !== 13'h0000) begin bad++; $display("FAIL wrap_zero got=%h want=%h", ir_pc, 13'h0000); end
      total++; if (ir !== rom_fn(13'h0000)) begin bad++; $display("FAIL wrap_ir got=%h want=%h", ir, rom_fn(13'h0000)); end
      total++;
      if ($isunknown({rom_addr, ir, ir_pc, valid, halted})) begin
         bad++; $display("FAIL wrap_x got=%h want=no X", {rom_addr, ir, ir_pc, valid, halted});
      end
   endtask

   task automatic test_halt();
      // IR holds addr 0, PC = 1
      ready = 1'b0; halt = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         total++; if (halted !== 1'b0) begin bad++; $display("FAIL halt_hold[%0d] got=%b want=0", i, halted); end
         total++; if (valid !== 1'b1) begin bad++; $display("FAIL halt_valid[%0d] got=%b want=1", i, valid); end
         total++; if (rom_addr !== 13'd1) begin bad++; $display("FAIL halt_addr[%0d] got=%h want=%h", i, rom_addr, 13'd1); end
      end
      ready = 1'b1;
      step();
      total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_drain got=%b want=1", halted); end
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL halt_dvalid got=%b want=0", valid); end
      step();
      total++; if (rom_addr !== 13'd1) begin bad++; $display("FAIL halt_freeze got=%h want=%h", rom_addr, 13'd1); end
      halt = 1'b0;
      step();
      total++; if (halted !== 1'b0) begin bad++; $display("FAIL halt_resume got=%b want=0", halted); end
      step();
      total++; if (ir_pc !== 13'd1) begin bad++; $display("FAIL halt_next got=%h want=%h", ir_pc, 13'd1); end
      total++; if (ir !== rom_fn(13'd1)) begin bad++; $display("FAIL halt_ir got=%h want=%h", ir, rom_fn(13'd1)); end
      step();
      total++; if (ir_pc !== 13'd2) begin bad++; $display("FAIL halt_next2 got=%h want=%h", ir_pc, 13'd2); end
   endtask

   task automatic test_halt_redirect();
      // IR holds addr 2, PC = 3; halt with decode ready drains in one cycle
      halt = 1'b1; ready = 1'b1;
      step();
      total++; if (halted !== 1'b1) begin bad++; $display("FAIL hr_halted got=%b want=1", halted); end
      br = 1'b1; br_addr = 13'h030;
      step();
      br = 1'b0;
      total++; if (rom_addr !== 13'h030) begin bad++; $display("FAIL hr_addr got=%h want=%h", rom_addr, 13'h030); end
      total++; if (halted !== 1'b1) begin bad++; $display("FAIL hr_still got=%b want=1", halted); end
      halt = 1'b0;
      step();
      step();
      total++; if (ir_pc !== 13'h030) begin bad++; $display("FAIL hr_fetch got=%h want=%h", ir_pc, 13'h030); end
      // simultaneous redirect and halt with an unconsumed IR
      br = 1'b1; br_addr = 13'h020; halt = 1'b1; ready = 1'b0;
      step();
      br = 1'b0;
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL bh_flush got=%b want=0", valid); end
      total++; if (halted !== 1'b1) begin bad++; $display("FAIL bh_halted got=%b want=1", halted); end
      total++; if (rom_addr !== 13'h020) begin bad++; $display("FAIL bh_addr got=%h want=%h", rom_addr, 13'h020); end
      halt = 1'b0; ready = 1'b1;
      step();
      step();
      total++; if (ir_pc !== 13'h020) begin bad++; $display("FAIL bh_fetch got=%h want=%h", ir_pc, 13'h020); end
      total++; if (ir !== rom_fn(13'h020)) begin bad++; $display("FAIL bh_ir got=%h want=%h", ir, rom_fn(13'h020)); end
   endtask

   task automatic test_reset_mid();
      ready = 1'b0;
      step();
      total++; if (valid !== 1'b1) begin bad++; $display("FAIL rm_pre got=%b want=1", valid); end
      #2 rst_n = 1'b0;
      #1;
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL rm_valid got=%b want=0", valid); end
      total++; if (ir !== 15'd0) begin bad++; $display("FAIL rm_ir got=%h want=%h", ir, 15'd0); end
      total++; if (ir_pc !== 13'd0) begin bad++; $display("FAIL rm_irpc got=%h want=%h", ir_pc, 13'd0); end
      total++; if (rom_addr !== 13'd0) begin bad++; $display("FAIL rm_addr got=%h want=%h", rom_addr, 13'd0); end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1; ready = 1'b1; br = 1'b1; br_addr = 13'h055;
      step();  // BOOT: redirect must be ignored
      br = 1'b0;
      total++; if (rom_addr !== 13'd0) begin bad++; $display("FAIL rm_bootbr got=%h want=%h", rom_addr, 13'd0); end
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL rm_boot got=%b want=0", valid); end
      step();
      total++; if (ir_pc !== 13'd0) begin bad++; $display("FAIL rm_fetch got=%h want=%h", ir_pc, 13'd0); end
      total++; if (ir !== rom_fn(13'd0)) begin bad++; $display("FAIL rm_ir0 got=%h want=%h", ir, rom_fn(13'd0)); end
      total++; if (rom_addr !== 13'd1) begin bad++; $display("FAIL rm_next got=%h want=%h", rom_addr, 13'd1); end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_branch();
      test_stall();
      test_wrap();
      test_halt();
      test_halt_redirect();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
